// File: rtl/jtframe_rst_seq_if.sv
// Signal bundle between the clock/PLL block (master) and jtframe_rst_seq (slave).
// All signals are plain levels except wdog_kick, a single-cycle pulse; there is no valid/ready handshake.
interface jtframe_rst_seq_if #(
    parameter int CH = 4
);
    logic          pll_locked;
    logic          game_rst;
    logic          wdog_kick;
    logic [CH-1:0] rst_out;
    logic          rst_done;
    logic          wdog_fired;
    logic [1:0]    seq_state;   // 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN

    modport master (
        output pll_locked,
        output game_rst,
        output wdog_kick,
        input  rst_out,
        input  rst_done,
        input  wdog_fired,
        input  seq_state
    );

    modport slave (
        input  pll_locked,
        input  game_rst,
        input  wdog_kick,
        output rst_out,
        output rst_done,
        output wdog_fired,
        output seq_state
    );
endinterface

// File: rtl/jtframe_rst_seq.sv
// Per-domain reset sequencer: filters PLL lock, holds reset, then releases CH resets in order.
// Optional run-time watchdog enabled by defining JTFRAME_RST_WDOG_EN.
module jtframe_rst_seq #(
    parameter int CH       = 4,
    parameter int LOCK_CNT = 256,
    parameter int HOLD     = 1024,
    parameter int STAGGER  = 64,
    parameter int WDOG     = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    jtframe_rst_seq_if.slave bus
);
    localparam int MAX_LH  = (LOCK_CNT > HOLD) ? LOCK_CNT : HOLD;
    localparam int MAX_SW  = (STAGGER > WDOG) ? STAGGER : WDOG;
    localparam int MAX_ALL = (MAX_LH > MAX_SW) ? MAX_LH : MAX_SW;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam int IW      = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HOLD = 2'd1,
        S_REL  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CH-1:0] rst_out_q, rst_out_d;
    logic          done_q, done_d;

    logic lk_meta, lk_s;
    logic gr_meta, gr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
            gr_meta <= 1'b0;
            gr_s    <= 1'b0;
        end else begin
            lk_meta <= bus.pll_locked;
            lk_s    <= lk_meta;
            gr_meta <= bus.game_rst;
            gr_s    <= gr_meta;
        end
    end

`ifdef JTFRAME_RST_WDOG_EN
    localparam logic [CW-1:0] WD_LAST = CW'(WDOG - 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_fire;
    logic          fired_q;

    // Only counts while RUN is going to persist; any exit or re-sequence parks it at 0.
    always_comb begin
        wd_fire  = 1'b0;
        wd_cnt_d = '0;
        if (state_q == S_RUN && lk_s && !gr_s) begin
            if (bus.wdog_kick)
                wd_cnt_d = '0;
            else if (wd_cnt_q == WD_LAST)
                wd_fire = 1'b1;
            else
                wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            fired_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            fired_q  <= fired_q | wd_fire;
        end
    end

    assign bus.wdog_fired = fired_q;
`else
    logic wd_fire;
    logic unused_kick;

    assign wd_fire        = 1'b0;
    assign unused_kick    = bus.wdog_kick;
    assign bus.wdog_fired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        // Lock loss beats game reset, which beats everything inside the states.
        if (state_q != S_WAIT && !lk_s) begin
            state_d   = S_WAIT;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else if ((state_q == S_REL || state_q == S_RUN) && gr_s) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (!lk_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (gr_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d     = '0;
                        idx_d     = '0;
                        rst_out_d = rst_out_q << 1;
                        if (CH == 1) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_REL;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_REL: begin
                    if (cnt_q == STAG_LAST) begin
                        // Shifting left releases the lowest still-asserted channel.
                        cnt_d     = '0;
                        idx_d     = idx_q + 1'b1;
                        rst_out_d = rst_out_q << 1;
                        if (int'(idx_q) == CH - 2) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_RUN: begin
                    if (wd_fire) begin
                        state_d   = S_HOLD;
                        cnt_d     = '0;
                        idx_d     = '0;
                        rst_out_d = '1;
                        done_d    = 1'b0;
                    end
                end

                default: begin
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.rst_done  = done_q;
    assign bus.seq_state = state_q;
endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Directed bench for jtframe_rst_seq with CH=3, LOCK_CNT=8, HOLD=16, STAGGER=4, WDOG=32.
// Edge numbers in tags count rising edges after the stimulus change that starts each scenario.
module tb_jtframe_rst_seq;
    localparam int CH = 3;
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic auto_kick = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    jtframe_rst_seq_if #(.CH(CH)) bus ();

    jtframe_rst_seq #(
        .CH       (CH),
        .LOCK_CNT (8),
        .HOLD     (16),
        .STAGGER  (4),
        .WDOG     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [CH-1:0] exp_out, input logic exp_done);
        check({tag, "_rst_out"}, 32'(bus.rst_out), 32'(exp_out));
        check({tag, "_done"}, 32'(bus.rst_done), 32'(exp_done));
    endtask

    // Called just after the edge that changed pll_locked (or game_rst) to start the lock filter.
    task automatic expect_release(input string tag);
        adv(25); check_out({tag, "_e25"}, 3'b111, 1'b0);
        adv(1);  check_out({tag, "_e26"}, 3'b110, 1'b0);
        check({tag, "_e26_state"}, 32'(bus.seq_state), 32'(ST_REL));
        adv(3);  check_out({tag, "_e29"}, 3'b110, 1'b0);
        adv(1);  check_out({tag, "_e30"}, 3'b100, 1'b0);
        adv(3);  check_out({tag, "_e33"}, 3'b100, 1'b0);
        adv(1);  check_out({tag, "_e34"}, 3'b000, 1'b1);
        check({tag, "_e34_state"}, 32'(bus.seq_state), 32'(ST_RUN));
    endtask

    // Keeps the optional watchdog quiet during scenarios that are not about it.
    initial begin
        forever begin
            repeat (16) @(posedge clk);
            #1;
            if (auto_kick) begin
                bus.wdog_kick = 1'b1;
                @(posedge clk);
                #1;
                bus.wdog_kick = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not reach the end of the directed sequence");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.game_rst   = 1'b0;
        bus.wdog_kick  = 1'b0;
        rst_n          = 1'b0;

        // Power-up
        adv(5);
        check_out("reset", 3'b111, 1'b0);
        check("reset_state", 32'(bus.seq_state), 32'(ST_WAIT));
        check("reset_fired", 32'(bus.wdog_fired), 32'd0);
        rst_n = 1'b1;
        bus.pll_locked = 1'b1;
        expect_release("pwr");

        // Lock loss in RUN: pll_locked falls at edge 100 of the power-up timeline
        adv(66);
        bus.pll_locked = 1'b0;
        adv(2); check_out("loss_e2", 3'b000, 1'b1);
        adv(1); check_out("loss_e3", 3'b111, 1'b0);
        check("loss_e3_state", 32'(bus.seq_state), 32'(ST_WAIT));
        adv(2);
        bus.pll_locked = 1'b1;
        expect_release("relock");

        // game_rst pulse of 10 cycles in RUN
        adv(10);
        bus.game_rst = 1'b1;
        adv(2); check_out("grst_e2", 3'b000, 1'b1);
        adv(1); check_out("grst_e3", 3'b111, 1'b0);
        check("grst_e3_state", 32'(bus.seq_state), 32'(ST_HOLD));
        adv(7);
        bus.game_rst = 1'b0;
        adv(17); check_out("grst_e27", 3'b111, 1'b0);
        adv(1);  check_out("grst_e28", 3'b110, 1'b0);
        adv(4);  check_out("grst_e32", 3'b100, 1'b0);
        adv(4);  check_out("grst_e36", 3'b000, 1'b1);

        // Simultaneous game_rst and lock loss
        adv(10);
        bus.game_rst   = 1'b1;
        bus.pll_locked = 1'b0;
        adv(3); check_out("both_e3", 3'b111, 1'b0);
        check("both_e3_state", 32'(bus.seq_state), 32'(ST_WAIT));
        adv(1);
        check("both_e4_state", 32'(bus.seq_state), 32'(ST_WAIT));
        adv(1);
        bus.game_rst   = 1'b0;
        bus.pll_locked = 1'b1;
        expect_release("both");

        // Asynchronous reset mid-run, no clock edge needed
        adv(20);
        auto_kick = 1'b0;
        bus.pll_locked = 1'b0;
        rst_n = 1'b0;
        #2;
        check_out("async_rst", 3'b111, 1'b0);
        check("async_rst_state", 32'(bus.seq_state), 32'(ST_WAIT));
        adv(2);

        // One-cycle lock glitch at edge 6 of the filter restarts it
        rst_n = 1'b1;
        bus.pll_locked = 1'b1;
        adv(6);
        bus.pll_locked = 1'b0;
        adv(1);
        bus.pll_locked = 1'b1;
        adv(9);  check_out("glitch_e16", 3'b111, 1'b0);
        check("glitch_e16_state", 32'(bus.seq_state), 32'(ST_WAIT));
        adv(1);
        check("glitch_e17_state", 32'(bus.seq_state), 32'(ST_HOLD));
        adv(15); check_out("glitch_e32", 3'b111, 1'b0);
        adv(1);  check_out("glitch_e33", 3'b110, 1'b0);
        adv(8);  check_out("glitch_e41", 3'b000, 1'b1);

`ifdef JTFRAME_RST_WDOG_EN
        // RUN entered at glitch edge 41; no kicks -> fires 32 edges later
        adv(31); check_out("wdog_e31", 3'b000, 1'b1);
        check("wdog_e31_fired", 32'(bus.wdog_fired), 32'd0);
        adv(1);  check_out("wdog_e32", 3'b111, 1'b0);
        check("wdog_e32_fired", 32'(bus.wdog_fired), 32'd1);
        check("wdog_e32_state", 32'(bus.seq_state), 32'(ST_HOLD));
        adv(16); check_out("wdog_e48", 3'b110, 1'b0);
        adv(8);  check_out("wdog_e56", 3'b000, 1'b1);
        for (int i = 0; i < 50; i++) begin
            adv(19);
            bus.wdog_kick = 1'b1;
            adv(1);
            bus.wdog_kick = 1'b0;
            check($sformatf("kick_%0d", i), 32'(bus.rst_out), 32'd0);
        end
        check("kick_fired_sticky", 32'(bus.wdog_fired), 32'd1);
        check("kick_state", 32'(bus.seq_state), 32'(ST_RUN));
`else
        // Without the watchdog, a long kick-free RUN leaves everything released
        adv(100);
        check_out("nowdog_run", 3'b000, 1'b1);
        check("nowdog_fired", 32'(bus.wdog_fired), 32'd0);
`endif

        rst_n = 1'b0;
        #2;
        check("final_fired_cleared", 32'(bus.wdog_fired), 32'd0);
        check_out("final_reset", 3'b111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
